// File: rtl/tiny1_mmio_hub_pkg.sv
// tiny1_mmio_pkg: shared constants for the tiny1 memory-mapped I/O hub.
// Holds the channel/global register offsets (addr[3:1]), the STATUS bit
// positions, the address bit that selects global space, and a helper that
// packs a channel STATUS word.
package tiny1_mmio_pkg;

  localparam int GLOBAL_BIT = 10;

  // Channel-space register offsets
  localparam logic [2:0] CH_STATUS  = 3'd0;
  localparam logic [2:0] CH_RXDATA  = 3'd1;
  localparam logic [2:0] CH_RXCOUNT = 3'd2;
  localparam logic [2:0] CH_TXDATA  = 3'd3;
  localparam logic [2:0] CH_CLEAR   = 3'd4;

  // Global-space register offsets
  localparam logic [2:0] G_GPIO     = 3'd0;
  localparam logic [2:0] G_IRQ_EN   = 3'd1;
  localparam logic [2:0] G_IRQ_PEND = 3'd2;
  localparam logic [2:0] G_EOI      = 3'd3;

  // STATUS bit positions
  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_READY    = 1;
  localparam int ST_RX_FULL     = 2;
  localparam int ST_TX_DROP     = 3;

  function automatic logic [15:0] status_word(input logic nonempty,
                                              input logic tx_ready,
                                              input logic rx_full,
                                              input logic tx_drop);
    logic [15:0] s;
    s                 = '0;
    s[ST_RX_NONEMPTY] = nonempty;
    s[ST_TX_READY]    = tx_ready;
    s[ST_RX_FULL]     = rx_full;
    s[ST_TX_DROP]     = tx_drop;
    return s;
  endfunction

endpackage

// File: rtl/tiny1_mmio_hub_if.sv
// tiny1_mmio_hub_if: core-side memory-mapped bus of the hub.
//   sel/addr/wr/rd/wdata : access from the core (sel = core address bit 15)
//   rdata                : registered read data from the hub
//   irq/irqack           : interrupt request and its acknowledge pulse
// modport master = core side, modport slave = hub side.
interface tiny1_mmio_hub_if;
  logic        sel;
  logic [10:0] addr;
  logic        wr;
  logic        rd;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        irq;
  logic        irqack;

  modport master (output sel, addr, wr, rd, wdata, irqack,
                  input  rdata, irq);
  modport slave  (input  sel, addr, wr, rd, wdata, irqack,
                  output rdata, irq);
endinterface

// File: rtl/tiny1_mmio_hub_rx_fifo.sv
// tiny1_rx_fifo: byte FIFO buffering one UART channel's received data.
//   clk, rst (sync, active-low)
//   push/din  : write a byte (ignored when full)
//   pop       : drop the head byte (ignored when empty)
//   dout      : head byte (combinational, meaningful only when !empty)
//   count     : occupancy 0..DEPTH; empty / full flags
module tiny1_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/tiny1_mmio_hub.sv
// tiny1_mmio_hub: memory-mapped hub giving the core access to NCH UART
// channels (RX FIFO with auto-drain, TX strobe), a GPIO register and an
// interrupt with acknowledge/EOI hold.
//   clk, rst (sync, active-low)
//   bus        : core access bus and irq/irqack (slave side)
//   uart_din   : RX bytes, 8 bits per channel; uart_valid: RX byte available
//   uart_ready : TX idle per channel
//   uart_rd    : RX consume pulse; uart_wr: TX strobe; uart_dout: TX bytes
//   gpio       : LED/GPIO output register
module tiny1_mmio_hub #(
  parameter int NCH     = 2,
  parameter int RXDEPTH = 8,
  parameter int GPIO_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  tiny1_mmio_hub_if.slave     bus,
  input  logic [8*NCH-1:0]    uart_din,
  input  logic [NCH-1:0]      uart_valid,
  input  logic [NCH-1:0]      uart_ready,
  output logic [NCH-1:0]      uart_rd,
  output logic [NCH-1:0]      uart_wr,
  output logic [8*NCH-1:0]    uart_dout,
  output logic [GPIO_W-1:0]   gpio
);
  import tiny1_mmio_pkg::*;

  localparam int CW = $clog2(RXDEPTH) + 1;

  logic [2:0]     ch_idx;
  logic [2:0]     reg_idx;
  logic           ch_acc;
  logic           glb_acc;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] tx_wr;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] pull;
  logic [NCH-1:0] guard;
  logic [NCH-1:0] tx_drop;
  logic [NCH-1:0] empty;
  logic [NCH-1:0] full;
  logic [7:0]     head [NCH];
  logic [CW-1:0]  cnt  [NCH];
  logic [NCH-1:0] irq_en;
  logic [NCH-1:0] pend;
  logic           hold;
  logic           hold_nxt;
  logic           eoi;
  logic [15:0]    rd_val;

  assign ch_idx  = bus.addr[6:4];
  assign reg_idx = bus.addr[3:1];
  assign glb_acc = bus.sel && bus.addr[GLOBAL_BIT];
  assign ch_acc  = bus.sel && !bus.addr[GLOBAL_BIT] && (int'(ch_idx) < NCH);

  always_comb begin
    pop   = '0;
    tx_wr = '0;
    clr   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_acc && ch_idx == 3'(c)) begin
        pop[c]   = bus.rd && reg_idx == CH_RXDATA;
        tx_wr[c] = bus.wr && reg_idx == CH_TXDATA;
        clr[c]   = bus.wr && reg_idx == CH_CLEAR;
      end
    end
  end

  // Pull a byte only when there is room and the previous cycle was not a
  // pull (the UART needs one cycle to present its next byte).
  assign pull    = uart_valid & ~full & ~guard & {NCH{rst}};
  assign uart_rd = pull;
  assign uart_wr = tx_wr & uart_ready & {NCH{rst}};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    tiny1_rx_fifo #(.DEPTH(RXDEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pull[c]),
      .pop   (pop[c]),
      .din   (uart_din[8*c +: 8]),
      .dout  (head[c]),
      .count (cnt[c]),
      .empty (empty[c]),
      .full  (full[c])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      guard     <= '0;
      tx_drop   <= '0;
      uart_dout <= '0;
    end else begin
      guard <= pull;
      for (int c = 0; c < NCH; c++) begin
        if (uart_wr[c]) uart_dout[8*c +: 8] <= bus.wdata[7:0];
        if (tx_wr[c] && !uart_ready[c]) tx_drop[c] <= 1'b1;
        else if (clr[c])                tx_drop[c] <= 1'b0;
      end
    end
  end

  // Interrupt: irqack wins over a simultaneous EOI. irq follows the
  // post-edge hold so an acknowledge drops it on the very next cycle.
  assign pend     = ~empty & irq_en;
  assign eoi      = glb_acc && bus.wr && reg_idx == G_EOI;
  assign hold_nxt = bus.irqack ? 1'b1 : (eoi ? 1'b0 : hold);

  always_comb begin
    rd_val = '0;
    if (ch_acc) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_idx == 3'(c)) begin
          case (reg_idx)
            CH_STATUS:  rd_val = status_word(!empty[c], uart_ready[c], full[c], tx_drop[c]);
            CH_RXDATA:  rd_val = empty[c] ? 16'h0000 : {8'h00, head[c]};
            CH_RXCOUNT: rd_val = 16'(cnt[c]);
            default:    rd_val = '0;
          endcase
        end
      end
    end else if (glb_acc) begin
      case (reg_idx)
        G_GPIO:     rd_val = 16'(gpio);
        G_IRQ_EN:   rd_val = 16'(irq_en);
        G_IRQ_PEND: rd_val = 16'(pend);
        default:    rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gpio      <= '0;
      irq_en    <= '0;
      hold      <= 1'b0;
      bus.irq   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      if (glb_acc && bus.wr && reg_idx == G_GPIO)   gpio   <= bus.wdata[GPIO_W-1:0];
      if (glb_acc && bus.wr && reg_idx == G_IRQ_EN) irq_en <= bus.wdata[NCH-1:0];
      hold    <= hold_nxt;
      bus.irq <= (|pend) && !hold_nxt;
      if (bus.sel && bus.rd) bus.rdata <= rd_val;
    end
  end

endmodule

// File: doc/tiny1_mmio_hub.md
TINY1_MMIO_HUB -- requirements
Module: tiny1_mmio_hub

Interface
REQ-001 Parameter NCH, default 2, SHALL set the number of UART channels (1..8).
REQ-002 Parameter RXDEPTH, default 8, SHALL set per-channel RX FIFO depth (power of 2, 2..64).
REQ-003 Parameter GPIO_W, default 8, SHALL set GPIO output width (1..16).
REQ-004 clk  in  1  clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 sel  in  1  high when core address bit 15 is set (mmap access).
REQ-007 addr  in  11  mmap byte offset (core address[10:0]).
REQ-008 wr / rd  in  1 each  core write / read strobes, qualified by sel.
REQ-009 wdata  in  16  core write data; rdata  out  16  registered read data.
REQ-010 uart_din  in  8*NCH  RX bytes; uart_valid  in  NCH  RX byte available; uart_ready  in  NCH  TX idle.
REQ-011 uart_rd  out  NCH  RX consume pulse; uart_wr  out  NCH  TX strobe; uart_dout  out  8*NCH  TX bytes.
REQ-012 irq  out  1  interrupt request; irqack  in  1  core acknowledge pulse.
REQ-013 gpio  out  GPIO_W  LED/GPIO register.

Function
REQ-014 Decode: addr[10]=0 channel space, channel=addr[6:4], register=addr[3:1]; addr[10]=1 global space, register=addr[3:1]; channel>=NCH or unmapped register SHALL read 0 and ignore writes.
REQ-015 Channel registers: 0 STATUS (R: bit0 rx_nonempty, bit1 tx_ready, bit2 rx_full, bit3 tx_drop sticky); 1 RXDATA (R: {8'b0, head byte}, pops); 2 RXCOUNT (R: occupancy); 3 TXDATA (W: send wdata[7:0]); 4 CLEAR (W: clear tx_drop).
REQ-016 Global registers: 0 GPIO (R/W, low GPIO_W bits); 1 IRQ_EN (R/W, bit c enables channel c); 2 IRQ_PEND (R: rx_nonempty & IRQ_EN); 3 EOI (W any value: clear irq hold).
REQ-017 rdata SHALL be loaded on the clock edge of the access cycle from the pre-edge state (1-cycle latency) and hold until the next rd.
REQ-018 Auto-drain: when uart_valid[c], FIFO c not full and no uart_rd[c] in the previous cycle, hub SHALL pulse uart_rd[c] one cycle and push uart_din[c] same edge.
REQ-019 The cycle after a uart_rd[c] pulse SHALL be a guard cycle: no new pull on channel c.
REQ-020 FIFO full: no pull; byte remains in the UART; rx_full=1.
REQ-021 Push and pop same cycle: both performed, count unchanged; pop of empty FIFO: rdata=0, no state change.
REQ-022 Read/write pointers SHALL wrap modulo RXDEPTH; count width clog2(RXDEPTH)+1, range 0..RXDEPTH.
REQ-023 TXDATA write with uart_ready[c]=1: uart_wr[c] high same cycle (combinational), uart_dout[c]=wdata[7:0]; with uart_ready[c]=0: no strobe, tx_drop[c] set.
REQ-024 uart_dout[c] SHALL be registered, holding the last written byte.
REQ-025 irq register SHALL be high when |IRQ_PEND and hold=0; irqack sets hold (irq low next cycle); EOI write clears hold; EOI and irqack together: hold set.

Reset
REQ-026 On rst=0 at an edge: FIFOs empty, pointers 0, tx_drop 0, IRQ_EN 0, hold 0, irq 0, gpio 0, rdata 0, uart_dout 0, guard cleared; uart_rd and uart_wr SHALL be 0 while rst=0.
REQ-027 Reset mid-transfer SHALL discard FIFO contents; no uart_rd pulse until the first cycle after release.

Structure
REQ-028 Package tiny1_mmio_pkg SHALL hold register offsets, STATUS bit positions and the global-space select bit.
REQ-029 Sub-module tiny1_rx_fifo (parameter DEPTH; push, pop, din, dout, count, empty, full) SHALL be instantiated once per channel via generate.

Verification
REQ-030 NCH=2: uart_valid[1]=1 with 0x41 -> uart_rd[1] one pulse, RXCOUNT1=1, RXDATA1 read returns 0x0041, RXCOUNT1=0.
REQ-031 Valid held with RXDEPTH=8 -> exactly 8 pulls at most every 2nd cycle, then rx_full=1, no uart_rd until a pop.
REQ-032 TXDATA0=0x55 with uart_ready[0]=1 -> uart_wr[0] pulse, uart_dout0=0x55; with ready=0 -> no pulse, STATUS0 bit3=1, CLEAR clears it.
REQ-033 IRQ_EN=0x1, byte on ch0 -> irq=1; irqack -> irq=0; EOI with byte still queued -> irq=1 next cycle.
REQ-034 Simultaneous pop and push at count=3 -> count stays 3, FIFO order preserved; read of ch 5 or addr 0x40E -> 0.
REQ-035 GPIO write 0xA5, rst pulse mid-drain -> gpio=0, FIFOs empty, irq=0.
